exp_product: RTL
================

# exp_product

Downstream stage of the multiplier decomposer in the e^X datapath. It captures the six Q15.11 factors when `mul_valid` pulses and multiplies them sequentially, one factor per cycle, starting from 1.0. It saturates on overflow and presents the final product as the exponential result with a single-cycle valid pulse.

## Interface
Parameters:
- `WIDTH`, 26: factor and result width (Q15.11).
- `FRAC`, 11: fractional bits.
- `NUM_MUL`, 6: number of factors per run.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mul_valid`  in  1  single-cycle pulse; factor inputs valid in the same cycle.
- `multiplier_0` … `multiplier_5`  in  26 each  factors, unsigned Q15.11.
- `exp_out`  out  26  product, unsigned Q15.11; reset 0.
- `exp_valid`  out  1  one-cycle pulse when `exp_out` updates; reset 0.
- `exp_ovf`  out  1  saturation occurred in the run that produced `exp_out`; reset 0.
- `busy`  out  1  high while in MUL; reset 0.
- `overrun`  out  1  sticky; a `mul_valid` arrived while busy. Cleared only by `rst`; reset 0.

## Operation
- FSM states: IDLE and MUL. Reset state is IDLE.
- IDLE, `mul_valid`=1:
  - Latch all six factors into the operand registers.
  - Set `acc` to `1<<FRAC` (2048), `idx` to 0 and the overflow-accumulate flag to 0.
  - Move to MUL.
- MUL, each cycle, with f = operand[`idx`]:
  - If f == 0, the slot is unused and treated as identity: `acc` is unchanged.
  - Otherwise p = (`acc` × f) >> `FRAC`, computed at full 52-bit precision and truncated (no rounding).
  - If p ≥ 2^26, `acc` ← 26'h3FFFFFF and the overflow flag is set. Otherwise `acc` ← p[25:0].
  - `idx` increments by 1.
- MUL, `idx` == `NUM_MUL`−1:
  - The final product is written directly to `exp_out`, and `exp_ovf` gets the run's overflow flag.
  - `exp_valid` ← 1 and the FSM returns to IDLE.
- Once saturated, `acc` stays at 26'h3FFFFFF for factors ≥ 1.0. Later factors < 1.0 still scale it down, with no special casing.
- `mul_valid` while in MUL is ignored: operands are untouched and `overrun` ← 1.
- `mul_valid` in the cycle the FSM returns to IDLE is ignored; that cycle is still MUL. A new run can start from the following cycle.
- `exp_out` and `exp_ovf` hold their values until the next completed run.

## Timing
- `mul_valid` high in cycle T → state MUL during T+1 … T+6 → `exp_valid` high in T+7 only.
- Latency is 7 cycles. Throughput is one run per 7 cycles.
- `busy` is high during T+1 … T+6 and low in T+7.
- `rst` is sampled at the rising edge and overrides everything.
- Reset mid-run:
  - FSM goes to IDLE and all outputs go to 0.
  - The partial product is discarded and no `exp_valid` is issued.
- `rst` and `mul_valid` in the same cycle: reset wins and no run starts.

## Structure
- Shared package `exp_pkg` holds:
  - `WIDTH`=26, `FRAC`=11, `NUM_MUL`=6.
  - `FX_ONE`=26'd2048, `FX_MAX`=26'h3FFFFFF.
  - The state enum {IDLE, MUL}.
- One sub-module, `fx_mul_sat`, combinational:
  - Inputs: `a` and `b`, 26 bits each.
  - Outputs: `p` (26 bits, truncated and saturated) and `sat` (1 bit).
  - It is reused by later stages.
- Top level contains the FSM, `idx` counter, operand registers, accumulator and output registers.

## Test plan
- Factors m0=4096 (2.0) and m1=3072 (1.5), others 0 → `exp_out`=6144 (3.0), `exp_ovf`=0, `exp_valid` exactly at T+7.
- All six factors = 2048 (1.0) → `exp_out`=2048; `busy` high exactly 6 cycles.
- Truncation: m0=m1=3, others 0 → after m0 `acc`=3; after m1 `acc`=(9>>11)=0 → `exp_out`=0, `exp_ovf`=0.
- Saturation: m0=m1=26'h3FFFFFF, others 0 → `exp_out`=26'h3FFFFFF, `exp_ovf`=1. Then m0=1024 (0.5), others 0 → `exp_out`=1024, `exp_ovf`=0.
- Second `mul_valid` at T+3 with different factors → first result unaffected, `overrun`=1 and stays 1. A pulse at T+8 starts a normal run.
- `rst` asserted at T+4 → no `exp_valid`, all outputs 0. A new run starting after reset completes correctly.

Source files
------------

// File: rtl/exp_product_pkg.sv
// exp_pkg: shared constants and types for the e^X product stage.
//   WIDTH/FRAC/NUM_MUL : Q15.11 format and factor count per run
//   FX_ONE / FX_MAX    : fixed-point 1.0 and the saturation value
//   state_t            : sequencer states of exp_product
package exp_pkg;

    localparam int unsigned WIDTH   = 26;
    localparam int unsigned FRAC    = 11;
    localparam int unsigned NUM_MUL = 6;

    localparam logic [WIDTH-1:0] FX_ONE = 26'd2048;
    localparam logic [WIDTH-1:0] FX_MAX = 26'h3FFFFFF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/exp_product_if.sv
// exp_product_if: factor input bundle and result outputs of exp_product.
//   mul_valid, multiplier_0..5 : run request and its six Q15.11 factors
//   exp_out, exp_valid, exp_ovf : result, one-cycle valid, saturation flag
//   busy, overrun               : run in progress, sticky request-while-busy
// master = producer of factors / consumer of results, slave = exp_product.
interface exp_product_if;

    logic                      mul_valid;
    logic [exp_pkg::WIDTH-1:0] multiplier_0;
    logic [exp_pkg::WIDTH-1:0] multiplier_1;
    logic [exp_pkg::WIDTH-1:0] multiplier_2;
    logic [exp_pkg::WIDTH-1:0] multiplier_3;
    logic [exp_pkg::WIDTH-1:0] multiplier_4;
    logic [exp_pkg::WIDTH-1:0] multiplier_5;
    logic [exp_pkg::WIDTH-1:0] exp_out;
    logic                      exp_valid;
    logic                      exp_ovf;
    logic                      busy;
    logic                      overrun;

    modport master (
        output mul_valid, multiplier_0, multiplier_1, multiplier_2,
               multiplier_3, multiplier_4, multiplier_5,
        input  exp_out, exp_valid, exp_ovf, busy, overrun
    );

    modport slave (
        input  mul_valid, multiplier_0, multiplier_1, multiplier_2,
               multiplier_3, multiplier_4, multiplier_5,
        output exp_out, exp_valid, exp_ovf, busy, overrun
    );

endinterface

// File: rtl/exp_product_fx_mul_sat.sv
// fx_mul_sat: combinational unsigned fixed-point multiply with saturation.
//   a, b : WIDTH-bit unsigned operands with FRAC fractional bits
//   p    : (a*b) >> FRAC, truncated; all-ones when it does not fit WIDTH bits
//   sat  : high when p was clamped
module fx_mul_sat #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned FRAC  = 11
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p,
    output logic             sat
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0] full;
    logic [PW-1:0] shifted;

    always_comb begin
        full    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        shifted = full >> FRAC;
        // Any bit above the result width means the product does not fit.
        sat     = |shifted[PW-1:WIDTH];
        p       = sat ? '1 : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/exp_product.sv
// exp_product: multiplies the six factors from the decomposer sequentially,
// one per cycle starting from 1.0, saturating on overflow.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : exp_product_if.slave -- factor inputs, result/status outputs
// A run takes NUM_MUL cycles in MUL; exp_valid pulses the cycle after.
module exp_product #(
    parameter int unsigned WIDTH   = exp_pkg::WIDTH,
    parameter int unsigned FRAC    = exp_pkg::FRAC,
    parameter int unsigned NUM_MUL = exp_pkg::NUM_MUL
) (
    input  logic          clk,
    input  logic          rst,
    exp_product_if.slave  bus
);

    import exp_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_MUL);
    localparam int unsigned NPORT = 6;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [WIDTH-1:0]  opnd [NUM_MUL];
    logic [WIDTH-1:0]  acc;
    logic              ovf_acc;

    logic [WIDTH-1:0]  mul_in [NPORT];
    logic [WIDTH-1:0]  cur_f;
    logic [WIDTH-1:0]  mul_p;
    logic              mul_sat;
    logic [WIDTH-1:0]  acc_nxt;
    logic              ovf_nxt;
    logic              last;

    always_comb begin
        mul_in[0] = bus.multiplier_0;
        mul_in[1] = bus.multiplier_1;
        mul_in[2] = bus.multiplier_2;
        mul_in[3] = bus.multiplier_3;
        mul_in[4] = bus.multiplier_4;
        mul_in[5] = bus.multiplier_5;
    end

    fx_mul_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mul (
        .a   (acc),
        .b   (cur_f),
        .p   (mul_p),
        .sat (mul_sat)
    );

    // A zero factor marks an unused slot and acts as identity.
    always_comb begin
        cur_f   = opnd[idx];
        acc_nxt = acc;
        ovf_nxt = ovf_acc;
        if (cur_f != '0) begin
            acc_nxt = mul_p;
            ovf_nxt = ovf_acc | mul_sat;
        end
        last = (idx == IDX_W'(NUM_MUL - 1));
    end

    assign bus.busy = (state == MUL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            acc           <= '0;
            ovf_acc       <= 1'b0;
            for (int unsigned i = 0; i < NUM_MUL; i++) begin
                opnd[i] <= '0;
            end
            bus.exp_out   <= '0;
            bus.exp_valid <= 1'b0;
            bus.exp_ovf   <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.exp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mul_valid) begin
                        for (int unsigned i = 0; i < NUM_MUL; i++) begin
                            opnd[i] <= mul_in[i];
                        end
                        acc     <= FX_ONE;
                        idx     <= '0;
                        ovf_acc <= 1'b0;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    // Requests during a run, including its final cycle, are dropped.
                    if (bus.mul_valid) begin
                        bus.overrun <= 1'b1;
                    end
                    acc     <= acc_nxt;
                    ovf_acc <= ovf_nxt;
                    idx     <= idx + 1'b1;
                    if (last) begin
                        bus.exp_out   <= acc_nxt;
                        bus.exp_ovf   <= ovf_nxt;
                        bus.exp_valid <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
